// File: rtl/score_display_driver.sv
// score_display_driver: converts two binary scores to BCD with shift-add-3 and
// scans them onto a 4-digit multiplexed active-low seven-segment display.
module score_display_driver #(
   parameter int W           = 7,
   parameter int MAXV        = 99,
   parameter int REFRESH_DIV = 100000,
   parameter int DIV_W       = 17
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] score_a,
   input  logic [W-1:0] score_b,
   output logic [6:0]   seg,
   output logic [3:0]   an,
   output logic         busy
);
   localparam int CW = $clog2(W + 1);
   localparam int SW = W + 8;
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t state_q, state_d;
   logic [W-1:0]     last_a_q, last_a_d, last_b_q, last_b_d;
   logic [SW-1:0]    sh_a_q, sh_a_d, sh_b_q, sh_b_d;
   logic [CW-1:0]    bit_q, bit_d;
   logic [7:0]       disp_a_q, disp_a_d, disp_b_q, disp_b_d;
   logic             ovf_a_q, ovf_a_d, ovf_b_q, ovf_b_d;
   logic [DIV_W-1:0] ref_q, ref_d;
   logic [1:0]       idx_q, idx_d;
   logic [3:0]       nib;
   logic             dash;

   // Register layout: {tens, ones, binary}; adjust both nibbles, then shift.
   function automatic logic [SW-1:0] dabble(input logic [SW-1:0] r);
      logic [SW-1:0] t;
      t = r;
      if (t[W+3:W] >= 4'd5) t[W+3:W] = t[W+3:W] + 4'd3;
      if (t[W+7:W+4] >= 4'd5) t[W+7:W+4] = t[W+7:W+4] + 4'd3;
      return t << 1;
   endfunction

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0: return 7'b1000000;
         4'd1: return 7'b1111001;
         4'd2: return 7'b0100100;
         4'd3: return 7'b0110000;
         4'd4: return 7'b0011001;
         4'd5: return 7'b0010010;
         4'd6: return 7'b0000010;
         4'd7: return 7'b1111000;
         4'd8: return 7'b0000000;
         4'd9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         last_a_q <= '0;
         last_b_q <= '0;
         sh_a_q   <= '0;
         sh_b_q   <= '0;
         bit_q    <= '0;
         disp_a_q <= '0;
         disp_b_q <= '0;
         ovf_a_q  <= 1'b0;
         ovf_b_q  <= 1'b0;
         ref_q    <= '0;
         idx_q    <= '0;
      end else begin
         state_q  <= state_d;
         last_a_q <= last_a_d;
         last_b_q <= last_b_d;
         sh_a_q   <= sh_a_d;
         sh_b_q   <= sh_b_d;
         bit_q    <= bit_d;
         disp_a_q <= disp_a_d;
         disp_b_q <= disp_b_d;
         ovf_a_q  <= ovf_a_d;
         ovf_b_q  <= ovf_b_d;
         ref_q    <= ref_d;
         idx_q    <= idx_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      last_a_d = last_a_q;
      last_b_d = last_b_q;
      sh_a_d   = sh_a_q;
      sh_b_d   = sh_b_q;
      bit_d    = bit_q;
      disp_a_d = disp_a_q;
      disp_b_d = disp_b_q;
      ovf_a_d  = ovf_a_q;
      ovf_b_d  = ovf_b_q;
      case (state_q)
         IDLE: if (score_a != last_a_q || score_b != last_b_q) begin
            last_a_d = score_a;
            last_b_d = score_b;
            sh_a_d   = SW'(score_a);
            sh_b_d   = SW'(score_b);
            bit_d    = '0;
            state_d  = SHIFT;
         end
         SHIFT: begin
            sh_a_d = dabble(sh_a_q);
            sh_b_d = dabble(sh_b_q);
            if (bit_q == CW'(W - 1)) state_d = DONE;
            else bit_d = bit_q + 1'b1;
         end
         DONE: begin
            disp_a_d = sh_a_q[W+7:W];
            disp_b_d = sh_b_q[W+7:W];
            ovf_a_d  = 32'(last_a_q) > MAXV;
            ovf_b_d  = 32'(last_b_q) > MAXV;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
      ref_d = (ref_q == DIV_W'(REFRESH_DIV - 1)) ? '0 : ref_q + 1'b1;
      idx_d = (ref_q == DIV_W'(REFRESH_DIV - 1)) ? idx_q + 2'd1 : idx_q;
   end

   always_comb begin
      busy = state_q != IDLE;
      an   = ~(4'b0001 << idx_q);
      nib  = idx_q[0] ? (idx_q[1] ? disp_a_q[7:4] : disp_b_q[7:4])
                      : (idx_q[1] ? disp_a_q[3:0] : disp_b_q[3:0]);
      dash = idx_q[1] ? ovf_a_q : ovf_b_q;
      seg  = dash ? 7'b0111111 : seg7(nib);
   end
endmodule
